sequence_control_mc: RTL and testbench

//  Multicycle instruction sequencer, successor to the fixed-timing fetch/decode FSM.

---
 rtl/seq_ctrl_pkg.sv | 54 +++++
 rtl/seq_branch_eval.sv | 26 ++
 rtl/sequence_control_mc.sv | 238 +++++++++++++++++++++++
 tb/tb_sequence_control_mc.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the multicycle instruction sequencer:
// opcodes, branch condition codes, state encoding and datapath mux select codes.
package seq_ctrl_pkg;

   // Controller states, 4-bit encoding
   typedef enum logic [3:0] {
      StReset  = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StMem    = 4'd3,
      StHalt   = 4'd4,
      StFault  = 4'd5,
      StIrq    = 4'd6
   } seq_state_e;

   // Opcodes (IR[DataWidth-1 -: 4])
   localparam logic [3:0] OpNop = 4'd0;
   localparam logic [3:0] OpLdi = 4'd1;
   localparam logic [3:0] OpLd  = 4'd2;
   localparam logic [3:0] OpSt  = 4'd3;
   localparam logic [3:0] OpStx = 4'd4;
   localparam logic [3:0] OpJpl = 4'd5;
   localparam logic [3:0] OpRet = 4'd6;
   localparam logic [3:0] OpBrd = 4'd7;
   localparam logic [3:0] OpAlu = 4'd8;
   localparam logic [3:0] OpHlt = 4'd15;

   // Branch condition codes
   localparam logic [1:0] CnBeq = 2'b00;
   localparam logic [1:0] CnBne = 2'b01;
   localparam logic [1:0] CnBlt = 2'b10;
   localparam logic [1:0] CnBcs = 2'b11;

   // PC source select
   localparam logic [1:0] PcSrcBranch = 2'b00;
   localparam logic [1:0] PcSrcReturn = 2'b01;
   localparam logic [1:0] PcSrcReg    = 2'b10;
   localparam logic [1:0] PcSrcIrqVec = 2'b11;

   // Register-file write data select
   localparam logic [1:0] DataSrcZext = 2'b00;
   localparam logic [1:0] DataSrcMem  = 2'b01;
   localparam logic [1:0] DataSrcAlu  = 2'b10;

   // Memory address select
   localparam logic [1:0] AddrSrcPc = 2'b00;
   localparam logic [1:0] AddrSrcIr = 2'b10;

   // Opcodes 9..14 are not assigned
   function automatic logic is_illegal_op(input logic [3:0] op);
      return (op >= 4'd9) && (op <= 4'd14);
   endfunction

endpackage

// File: rtl/seq_branch_eval.sv
// Branch condition evaluator: condition code plus {V,N,C,Z} flags -> taken.
module seq_branch_eval
   import seq_ctrl_pkg::*;
(
   input  logic [1:0] Cn,
   input  logic [3:0] Flags,
   output logic       Taken
);

   logic flag_v, flag_n, flag_c, flag_z;

   assign {flag_v, flag_n, flag_c, flag_z} = Flags;

   // Decode the condition against the current flags
   always_comb begin
      Taken = 1'b0;
      unique case (Cn)
         CnBeq:   Taken = flag_z;
         CnBne:   Taken = ~flag_z;
         CnBlt:   Taken = flag_n ^ flag_v;
         CnBcs:   Taken = flag_c;
         default: Taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/sequence_control_mc.sv
// Multicycle instruction sequencer with MEM_Req/MEM_Rdy wait states, timeout fault,
// retired-instruction counter and optional interrupt entry.
// Optional feature: define SEQ_IRQ_EN to enable the IRQ state, IE flag and IrqAck.
module sequence_control_mc
   import seq_ctrl_pkg::*;
#(
   parameter int unsigned DataWidth  = 16,
   parameter int unsigned WaitMax    = 15,
   parameter int unsigned CountWidth = 32
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [DataWidth-1:0]  IR,
   input  logic [3:0]            ALU_FlgsIn,
   input  logic                  MEM_Rdy,
   input  logic                  Irq,
   output logic                  MEM_Req,
   output logic                  MEM_Wr,
   output logic [1:0]            ADDR_Src,
   output logic                  IR_Ld,
   output logic                  PC_Inc,
   output logic                  PC_Ld,
   output logic                  PC_Rst,
   output logic                  STK_Ld,
   output logic                  BRA_Src,
   output logic                  REG_WE,
   output logic                  FLG_Ld,
   output logic [1:0]            PC_Src,
   output logic [1:0]            DATA_Src,
   output logic                  Src1_Sel,
   output logic                  IrqAck,
   output logic                  Halt,
   output logic                  Fault,
   output logic [CountWidth-1:0] InstRet
);

   localparam logic [7:0] WaitLimit = 8'(WaitMax);

   seq_state_e            state_q, state_d;
   logic [7:0]            wait_cnt_q, wait_cnt_d;
   logic [CountWidth-1:0] inst_ret_q;
   logic                  retire;
   logic                  irq_take;
   logic                  br_taken;
   logic [3:0]            opcode;
   logic [1:0]            cond;
   logic                  unused_bits;

   assign opcode  = IR[DataWidth-1 -: 4];
   assign cond    = IR[DataWidth-5 -: 2];
   assign InstRet = inst_ret_q;

`ifdef SEQ_IRQ_EN
   logic ie_q, ie_d;
   assign irq_take    = Irq & ie_q;
   assign unused_bits = ^IR[DataWidth-7:0];
`else
   assign irq_take    = 1'b0;
   assign unused_bits = ^{IR[DataWidth-7:0], Irq};
`endif

   seq_branch_eval u_branch_eval (
      .Cn    (cond),
      .Flags (ALU_FlgsIn),
      .Taken (br_taken)
   );

   // State register, wait counter, retire counter and interrupt enable
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= StReset;
         wait_cnt_q <= '0;
         inst_ret_q <= '0;
`ifdef SEQ_IRQ_EN
         ie_q       <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (retire) inst_ret_q <= inst_ret_q + 1'b1;
`ifdef SEQ_IRQ_EN
         ie_q       <= ie_d;
`endif
      end
   end

   // Next-state logic; wait counter defaults to 0 so it clears on every state entry
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      retire     = 1'b0;
`ifdef SEQ_IRQ_EN
      ie_d       = ie_q;
`endif
      case (state_q)
         StReset: state_d = StFetch;
         StFetch: begin
            if (MEM_Rdy)                          state_d = StDecode;
            else if (wait_cnt_q + 8'd1 == WaitLimit) state_d = StFault;
            else                                  wait_cnt_d = wait_cnt_q + 8'd1;
         end
         StDecode: begin
            if (opcode == OpLd || opcode == OpSt || opcode == OpStx) begin
               state_d = StMem;
            end else if (opcode == OpHlt) begin
               retire  = 1'b1;
               state_d = StHalt;
            end else if (is_illegal_op(opcode)) begin
               state_d = StFault;
            end else begin
               retire  = 1'b1;
               state_d = irq_take ? StIrq : StFetch;
`ifdef SEQ_IRQ_EN
               if (opcode == OpRet) ie_d = 1'b1;
`endif
            end
         end
         StMem: begin
            if (MEM_Rdy) begin
               retire  = 1'b1;
               state_d = irq_take ? StIrq : StFetch;
            end else if (wait_cnt_q + 8'd1 == WaitLimit) begin
               state_d = StFault;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         StHalt:  state_d = StHalt;
         StFault: state_d = StFault;
`ifdef SEQ_IRQ_EN
         StIrq: begin
            ie_d    = 1'b0;
            state_d = StFetch;
         end
`endif
         default: state_d = StFault;
      endcase
   end

   // Control outputs from state, IR, flags and MEM_Rdy
   always_comb begin
      MEM_Req  = 1'b0;
      MEM_Wr   = 1'b0;
      ADDR_Src = AddrSrcPc;
      IR_Ld    = 1'b0;
      PC_Inc   = 1'b0;
      PC_Ld    = 1'b0;
      PC_Rst   = 1'b0;
      STK_Ld   = 1'b0;
      BRA_Src  = 1'b0;
      REG_WE   = 1'b0;
      FLG_Ld   = 1'b0;
      PC_Src   = PcSrcBranch;
      DATA_Src = DataSrcZext;
      Src1_Sel = 1'b0;
      IrqAck   = 1'b0;
      Halt     = 1'b0;
      Fault    = 1'b0;
      case (state_q)
         StReset: PC_Rst = 1'b1;
         StFetch: begin
            MEM_Req  = 1'b1;
            ADDR_Src = AddrSrcPc;
            IR_Ld    = MEM_Rdy;
            PC_Inc   = MEM_Rdy;
         end
         StDecode: begin
            case (opcode)
               OpLdi: begin
                  REG_WE   = 1'b1;
                  DATA_Src = DataSrcZext;
               end
               OpJpl: begin
                  PC_Ld    = 1'b1;
                  PC_Src   = PcSrcReg;
                  Src1_Sel = 1'b1;
                  STK_Ld   = ~IR[DataWidth-5];
               end
               OpRet: begin
                  PC_Ld  = 1'b1;
                  PC_Src = PcSrcReturn;
               end
               OpBrd: begin
                  PC_Ld   = br_taken;
                  BRA_Src = br_taken;
                  PC_Src  = PcSrcBranch;
               end
               OpAlu: begin
                  REG_WE   = 1'b1;
                  FLG_Ld   = 1'b1;
                  DATA_Src = DataSrcAlu;
               end
               default: ;
            endcase
         end
         StMem: begin
            MEM_Req  = 1'b1;
            ADDR_Src = AddrSrcIr;
            if (opcode == OpSt) begin
               MEM_Wr   = 1'b1;
               Src1_Sel = 1'b0;
            end else if (opcode == OpStx) begin
               MEM_Wr   = 1'b1;
               Src1_Sel = 1'b1;
            end else if (MEM_Rdy) begin
               REG_WE   = 1'b1;
               DATA_Src = DataSrcMem;
            end
         end
         StHalt: Halt = 1'b1;
         StFault: begin
            Fault = 1'b1;
            Halt  = 1'b1;
         end
`ifdef SEQ_IRQ_EN
         StIrq: begin
            STK_Ld = 1'b1;
            PC_Ld  = 1'b1;
            PC_Src = PcSrcIrqVec;
            IrqAck = 1'b1;
         end
`endif
         default: ;
      endcase
      // A reset cycle must not commit anything into the datapath
      if (Reset) begin
         MEM_Wr = 1'b0;
         IR_Ld  = 1'b0;
         PC_Inc = 1'b0;
         PC_Ld  = 1'b0;
         STK_Ld = 1'b0;
         REG_WE = 1'b0;
         FLG_Ld = 1'b0;
         IrqAck = 1'b0;
      end
   end

endmodule

// File: tb/tb_sequence_control_mc.sv
// Directed bench for sequence_control_mc (InstRet narrowed to 4 bits to exercise wrap).
// Covers SEQ_IRQ_EN in either build.
module tb_sequence_control_mc;

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 4;

   // Packed control view: bit positions used for expected values
   localparam logic [19:0] C_REQ   = 20'h80000;
   localparam logic [19:0] C_WR    = 20'h40000;
   localparam logic [19:0] C_ADDR  = 20'h20000;
   localparam logic [19:0] C_IRLD  = 20'h08000;
   localparam logic [19:0] C_PCINC = 20'h04000;
   localparam logic [19:0] C_PCLD  = 20'h02000;
   localparam logic [19:0] C_PCRST = 20'h01000;
   localparam logic [19:0] C_STK   = 20'h00800;
   localparam logic [19:0] C_BRA   = 20'h00400;
   localparam logic [19:0] C_WE    = 20'h00200;
   localparam logic [19:0] C_FLG   = 20'h00100;
   localparam logic [19:0] PCS_RET = 20'h00040;
   localparam logic [19:0] PCS_REG = 20'h00080;
   localparam logic [19:0] PCS_IRQ = 20'h000C0;
   localparam logic [19:0] DS_MEM  = 20'h00010;
   localparam logic [19:0] DS_ALU  = 20'h00020;
   localparam logic [19:0] C_S1    = 20'h00008;
   localparam logic [19:0] C_ACK   = 20'h00004;
   localparam logic [19:0] C_HALT  = 20'h00002;
   localparam logic [19:0] C_FAULT = 20'h00001;
   localparam logic [19:0] FETCH_OK = C_REQ | C_IRLD | C_PCINC;

   logic          Clk, Reset, MEM_Rdy, Irq;
   logic [DW-1:0] IR;
   logic [3:0]    ALU_FlgsIn;
   logic          MEM_Req, MEM_Wr, IR_Ld, PC_Inc, PC_Ld, PC_Rst, STK_Ld, BRA_Src;
   logic          REG_WE, FLG_Ld, Src1_Sel, IrqAck, Halt, Fault;
   logic [1:0]    ADDR_Src, PC_Src, DATA_Src;
   logic [CW-1:0] InstRet;
   logic [19:0]   ctl;

   int vectors     = 0;
   int miscompares = 0;

   assign ctl = {MEM_Req, MEM_Wr, ADDR_Src, IR_Ld, PC_Inc, PC_Ld, PC_Rst, STK_Ld, BRA_Src,
                 REG_WE, FLG_Ld, PC_Src, DATA_Src, Src1_Sel, IrqAck, Halt, Fault};

   sequence_control_mc #(
      .DataWidth  (DW),
      .WaitMax    (15),
      .CountWidth (CW)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .IR         (IR),
      .ALU_FlgsIn (ALU_FlgsIn),
      .MEM_Rdy    (MEM_Rdy),
      .Irq        (Irq),
      .MEM_Req    (MEM_Req),
      .MEM_Wr     (MEM_Wr),
      .ADDR_Src   (ADDR_Src),
      .IR_Ld      (IR_Ld),
      .PC_Inc     (PC_Inc),
      .PC_Ld      (PC_Ld),
      .PC_Rst     (PC_Rst),
      .STK_Ld     (STK_Ld),
      .BRA_Src    (BRA_Src),
      .REG_WE     (REG_WE),
      .FLG_Ld     (FLG_Ld),
      .PC_Src     (PC_Src),
      .DATA_Src   (DATA_Src),
      .Src1_Sel   (Src1_Sel),
      .IrqAck     (IrqAck),
      .Halt       (Halt),
      .Fault      (Fault),
      .InstRet    (InstRet)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // Leaves the DUT in RESET with Reset released
   task automatic do_reset;
      Reset = 1'b1;
      tick();
      tick();
      tick();
      Reset = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      IR = '0; MEM_Rdy = 1'b1; ALU_FlgsIn = '0; Irq = 1'b0;
      Reset = 1'b1;
      tick(); tick(); tick();
      vectors++;
      if (ctl !== C_PCRST) begin
         miscompares++; $display("FAIL reset_ctl: got %h expected %h", ctl, C_PCRST);
      end
      vectors++;
      if (InstRet !== 4'd0) begin
         miscompares++; $display("FAIL reset_instret: got %0d expected 0", InstRet);
      end
      Reset = 1'b0;
      #1;
      tick();
      vectors++;
      if (ctl !== FETCH_OK) begin
         miscompares++; $display("FAIL first_fetch: got %h expected %h", ctl, FETCH_OK);
      end
      tick();
      vectors++;
      if (ctl !== 20'h0) begin
         miscompares++; $display("FAIL nop_decode: got %h expected 00000", ctl);
      end
      tick();
      vectors++;
      if (InstRet !== 4'd1) begin
         miscompares++; $display("FAIL nop_retire1: got %0d expected 1", InstRet);
      end
      repeat (4) tick();
      vectors++;
      if (InstRet !== 4'd3) begin
         miscompares++; $display("FAIL nop_retire3: got %0d expected 3", InstRet);
      end
   endtask

   task automatic test_wrap;
      IR = '0; MEM_Rdy = 1'b1;
      do_reset();
      tick();
      repeat (30) tick();
      vectors++;
      if (InstRet !== 4'hF) begin
         miscompares++; $display("FAIL instret_max: got %0d expected 15", InstRet);
      end
      tick(); tick();
      vectors++;
      if (InstRet !== 4'h0) begin
         miscompares++; $display("FAIL instret_wrap: got %0d expected 0", InstRet);
      end
   endtask

   task automatic test_load_wait;
      IR = 16'h2005; MEM_Rdy = 1'b1;
      do_reset();
      tick();
      tick();
      vectors++;
      if (ctl !== 20'h0) begin
         miscompares++; $display("FAIL ld_decode: got %h expected 00000", ctl);
      end
      MEM_Rdy = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (ctl !== (C_REQ | C_ADDR)) begin
            miscompares++;
            $display("FAIL ld_wait%0d: got %h expected %h", i, ctl, C_REQ | C_ADDR);
         end
         tick();
      end
      MEM_Rdy = 1'b1;
      #1;
      vectors++;
      if (ctl !== (C_REQ | C_ADDR | C_WE | DS_MEM)) begin
         miscompares++;
         $display("FAIL ld_done: got %h expected %h", ctl, C_REQ | C_ADDR | C_WE | DS_MEM);
      end
      vectors++;
      if (InstRet !== 4'd0) begin
         miscompares++; $display("FAIL ld_pre_retire: got %0d expected 0", InstRet);
      end
      tick();
      vectors++;
      if (InstRet !== 4'd1 || ctl !== FETCH_OK) begin
         miscompares++;
         $display("FAIL ld_retire: got %0d/%h expected 1/%h", InstRet, ctl, FETCH_OK);
      end
      IR = 16'h3000;
      tick(); tick();
      vectors++;
      if (ctl !== (C_REQ | C_ADDR | C_WR)) begin
         miscompares++; $display("FAIL st_mem: got %h expected %h", ctl, C_REQ | C_ADDR | C_WR);
      end
      tick();
      IR = 16'h4000;
      tick(); tick();
      vectors++;
      if (ctl !== (C_REQ | C_ADDR | C_WR | C_S1)) begin
         miscompares++;
         $display("FAIL stx_mem: got %h expected %h", ctl, C_REQ | C_ADDR | C_WR | C_S1);
      end
      tick();
      vectors++;
      if (InstRet !== 4'd3) begin
         miscompares++; $display("FAIL store_retire: got %0d expected 3", InstRet);
      end
   endtask

   task automatic test_timeout;
      IR = '0; MEM_Rdy = 1'b0;
      do_reset();
      tick();
      for (int i = 0; i < 15; i++) begin
         vectors++;
         if (ctl !== C_REQ) begin
            miscompares++; $display("FAIL fetch_wait%0d: got %h expected %h", i, ctl, C_REQ);
         end
         tick();
      end
      vectors++;
      if (ctl !== (C_HALT | C_FAULT)) begin
         miscompares++; $display("FAIL timeout_fault: got %h expected %h", ctl, C_HALT | C_FAULT);
      end
      MEM_Rdy = 1'b1;
      repeat (3) tick();
      vectors++;
      if (ctl !== (C_HALT | C_FAULT)) begin
         miscompares++; $display("FAIL fault_held: got %h expected %h", ctl, C_HALT | C_FAULT);
      end
      Reset = 1'b1;
      tick();
      vectors++;
      if (ctl !== C_PCRST) begin
         miscompares++; $display("FAIL fault_reset: got %h expected %h", ctl, C_PCRST);
      end
      Reset = 1'b0;
   endtask

   task automatic test_decode_ops;
      logic [15:0] irs  [12] = '{16'h0000, 16'h1000, 16'h8000, 16'h5000, 16'h5800, 16'h6000,
                                 16'h7000, 16'h7400, 16'h7800, 16'h7C00, 16'h7C00, 16'h7800};
      logic [3:0]  flgs [12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                 4'b0001, 4'b0001, 4'b0100, 4'b0000, 4'b0010, 4'b1100};
      logic [19:0] exps [12] = '{20'h0, C_WE, C_WE | C_FLG | DS_ALU,
                                 C_PCLD | PCS_REG | C_S1 | C_STK, C_PCLD | PCS_REG | C_S1,
                                 C_PCLD | PCS_RET, C_PCLD | C_BRA, 20'h0, C_PCLD | C_BRA,
                                 20'h0, C_PCLD | C_BRA, 20'h0};
      MEM_Rdy = 1'b1; IR = '0;
      do_reset();
      tick();
      for (int i = 0; i < 12; i++) begin
         IR = irs[i];
         ALU_FlgsIn = flgs[i];
         tick();
         vectors++;
         if (ctl !== exps[i]) begin
            miscompares++;
            $display("FAIL decode_%h_f%b: got %h expected %h", irs[i], flgs[i], ctl, exps[i]);
         end
         tick();
      end
      vectors++;
      if (InstRet !== 4'd12) begin
         miscompares++; $display("FAIL decode_retire: got %0d expected 12", InstRet);
      end
      ALU_FlgsIn = '0;
   endtask

   task automatic test_illegal_halt;
      logic [15:0] bad [2] = '{16'h9000, 16'hE000};
      MEM_Rdy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         IR = '0;
         do_reset();
         tick();
         IR = bad[i];
         tick(); tick();
         vectors++;
         if (ctl !== (C_HALT | C_FAULT) || InstRet !== 4'd0) begin
            miscompares++;
            $display("FAIL illegal_%h: got %h/%0d expected %h/0", bad[i], ctl, InstRet,
                     C_HALT | C_FAULT);
         end
      end
      IR = '0;
      do_reset();
      tick();
      IR = 16'hF000;
      tick(); tick();
      vectors++;
      if (ctl !== C_HALT || InstRet !== 4'd1) begin
         miscompares++;
         $display("FAIL halt: got %h/%0d expected %h/1", ctl, InstRet, C_HALT);
      end
      repeat (3) tick();
      vectors++;
      if (ctl !== C_HALT || InstRet !== 4'd1) begin
         miscompares++;
         $display("FAIL halt_held: got %h/%0d expected %h/1", ctl, InstRet, C_HALT);
      end
   endtask

   task automatic test_reset_mid_mem;
      IR = 16'h2005; MEM_Rdy = 1'b1;
      do_reset();
      tick();
      tick();
      MEM_Rdy = 1'b0;
      tick();
      Reset = 1'b1;
      MEM_Rdy = 1'b1;
      #1;
      vectors++;
      if (REG_WE !== 1'b0) begin
         miscompares++; $display("FAIL reset_mem_we: got %b expected 0", REG_WE);
      end
      tick();
      vectors++;
      if (ctl !== C_PCRST || InstRet !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_mem_drop: got %h/%0d expected %h/0", ctl, InstRet, C_PCRST);
      end
      Reset = 1'b0;
   endtask

   task automatic test_irq;
      IR = '0; MEM_Rdy = 1'b1; Irq = 1'b0;
      do_reset();
      tick();
      IR = 16'h8000;
      Irq = 1'b1;
      tick();
      vectors++;
      if (ctl !== (C_WE | C_FLG | DS_ALU)) begin
         miscompares++; $display("FAIL irq_alu: got %h expected %h", ctl, C_WE | C_FLG | DS_ALU);
      end
      tick();
`ifdef SEQ_IRQ_EN
      vectors++;
      if (ctl !== (C_STK | C_PCLD | PCS_IRQ | C_ACK)) begin
         miscompares++;
         $display("FAIL irq_entry: got %h expected %h", ctl, C_STK | C_PCLD | PCS_IRQ | C_ACK);
      end
      tick();
      IR = 16'h0000;
      tick(); tick();
      vectors++;
      if (ctl !== FETCH_OK) begin
         miscompares++; $display("FAIL irq_masked: got %h expected %h", ctl, FETCH_OK);
      end
      IR = 16'h6000;
      tick(); tick();
      vectors++;
      if (ctl !== FETCH_OK) begin
         miscompares++; $display("FAIL irq_ret: got %h expected %h", ctl, FETCH_OK);
      end
      IR = 16'h0000;
      tick(); tick();
      vectors++;
      if (ctl !== (C_STK | C_PCLD | PCS_IRQ | C_ACK)) begin
         miscompares++;
         $display("FAIL irq_reenable: got %h expected %h", ctl, C_STK | C_PCLD | PCS_IRQ | C_ACK);
      end
`else
      vectors++;
      if (ctl !== FETCH_OK) begin
         miscompares++; $display("FAIL irq_ignored: got %h expected %h", ctl, FETCH_OK);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++;
         if (IrqAck !== 1'b0) begin
            miscompares++; $display("FAIL irqack_tied%0d: got %b expected 0", i, IrqAck);
         end
      end
`endif
      Irq = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; IR = '0; ALU_FlgsIn = '0; MEM_Rdy = 1'b1; Irq = 1'b0;
      test_reset();
      test_wrap();
      test_load_wait();
      test_timeout();
      test_decode_ops();
      test_illegal_halt();
      test_reset_mid_mem();
      test_irq();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
